// File: rtl/icache_refill_if.sv
// Bundle of signals between the refill controller and the IF stage, cache SRAM and memory bus.
// The slave modport is the controller's view; the master modport is the environment's view.
interface icache_refill_if #(
  parameter int BLOCK_ADDR_BITS = 28,
  parameter int BLOCK_BITS      = 128,
  parameter int BUS_BITS        = 32
);
  localparam int OFS = $clog2(BLOCK_BITS / 8);

  logic                           fetch_ren;
  logic [BLOCK_ADDR_BITS-1:0]     fetch_baddr;
  logic                           cache_hit;
  logic                           cache_ren;
  logic                           cache_wen;
  logic [BLOCK_ADDR_BITS-1:0]     cache_baddr;
  logic [BLOCK_BITS-1:0]          cache_wdata;
  logic                           stall;
  logic                           mem_req;
  logic [BLOCK_ADDR_BITS+OFS-1:0] mem_addr;
  logic                           mem_gnt;
  logic                           mem_rvalid;
  logic [BUS_BITS-1:0]            mem_rdata;
  logic [31:0]                    miss_cnt;

  modport slave (
    input  fetch_ren, fetch_baddr, cache_hit, mem_gnt, mem_rvalid, mem_rdata,
    output cache_ren, cache_wen, cache_baddr, cache_wdata, stall, mem_req, mem_addr, miss_cnt
  );

  modport master (
    output fetch_ren, fetch_baddr, cache_hit, mem_gnt, mem_rvalid, mem_rdata,
    input  cache_ren, cache_wen, cache_baddr, cache_wdata, stall, mem_req, mem_addr, miss_cnt
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill engine: detects a fetch miss, reads the block from memory beat by beat,
// and writes the assembled block into the cache SRAM with a single write pulse.
module icache_refill_ctrl #(
  parameter int BLOCK_ADDR_BITS = 28,
  parameter int BLOCK_BITS      = 128,
  parameter int BUS_BITS        = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  icache_refill_if.slave bus
);
  localparam int BEATS = BLOCK_BITS / BUS_BITS;
  localparam int OFS   = $clog2(BLOCK_BITS / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_WRITE} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [BLOCK_ADDR_BITS-1:0] r_miss_addr;
  logic [CNT_W-1:0]           r_beat_cnt;
  logic [BLOCK_BITS-1:0]      r_buf;
  logic [31:0]                r_miss_cnt;
  logic                       w_miss;
  logic                       w_last_beat;

  assign w_miss      = bus.fetch_ren && !bus.cache_hit;
  assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_miss)                         w_state_next = S_REQ;
      S_REQ:   if (bus.mem_gnt)                    w_state_next = S_FILL;
      S_FILL:  if (bus.mem_rvalid && w_last_beat)  w_state_next = S_WRITE;
      S_WRITE:                                     w_state_next = S_IDLE;
      default:                                     w_state_next = S_IDLE;
    endcase
  end

  // Read enable is only ever driven in IDLE, so it can never collide with the write pulse.
  always_comb begin
    bus.cache_ren   = 1'b0;
    bus.cache_wen   = 1'b0;
    bus.cache_baddr = r_miss_addr;
    bus.mem_req     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.cache_ren   = bus.fetch_ren;
        bus.cache_baddr = bus.fetch_baddr;
      end
      S_REQ:   bus.mem_req   = 1'b1;
      S_WRITE: bus.cache_wen = 1'b1;
      default: ;
    endcase
    bus.stall = (r_state != S_IDLE) || w_miss;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_miss_addr <= '0;
      r_beat_cnt  <= '0;
      r_buf       <= '0;
      r_miss_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_miss) r_miss_addr <= bus.fetch_baddr;
        S_REQ:  if (bus.mem_gnt) r_beat_cnt <= '0;
        S_FILL: begin
          if (bus.mem_rvalid) begin
            r_buf[r_beat_cnt*BUS_BITS +: BUS_BITS] <= bus.mem_rdata;
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
          end
        end
        S_WRITE: if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
        default: ;
      endcase
    end
  end

  assign bus.mem_addr    = {r_miss_addr, {OFS{1'b0}}};
  assign bus.cache_wdata = r_buf;
  assign bus.miss_cnt    = r_miss_cnt;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized self-checking bench: a transaction-level cache/memory model predicts every refill.
module tb_icache_refill_ctrl;
  localparam int BAB   = 28;
  localparam int BB    = 128;
  localparam int BUS   = 32;
  localparam int BEATS = BB / BUS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_refill_if #(.BLOCK_ADDR_BITS(BAB), .BLOCK_BITS(BB), .BUS_BITS(BUS)) bus();
  icache_refill_ctrl #(.BLOCK_ADDR_BITS(BAB), .BLOCK_BITS(BB), .BUS_BITS(BUS)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int wen_pulses = 0;
  int exp_pulses = 0;
  bit cached [logic [BAB-1:0]];
  logic [31:0]     exp_miss_cnt = 0;
  logic [BB-1:0]   last_block = '0;
  logic [BUS-1:0]  fixed_beats [BEATS];
  bit              use_fixed = 0;
  logic [BAB-1:0]  pool [16];

  always @(posedge clk) if (bus.cache_wen) wen_pulses++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_busy(input string ph);
    chk({ph, "_stall"}, bus.stall, 1);
    chk({ph, "_wen"}, bus.cache_wen, 0);
    chk({ph, "_ren"}, bus.cache_ren, 0);
  endtask

  // One fetch transaction: a hit is checked for zero overhead, a miss is serviced end to end.
  task automatic do_access(input logic [BAB-1:0] a, input int gnt_dly, input int gap,
                           input bit chg_addr, input bit stray);
    logic [BUS-1:0] beats [BEATS];
    logic [BB-1:0]  blk;
    int             ng;
    for (int b = 0; b < BEATS; b++) beats[b] = use_fixed ? fixed_beats[b] : $urandom;
    blk = '0;
    for (int b = BEATS - 1; b >= 0; b--) blk = (blk << BUS) | BB'(beats[b]);

    bus.fetch_ren   = 1'b1;
    bus.fetch_baddr = a;
    bus.cache_hit   = cached.exists(a) != 0;
    bus.mem_gnt     = 1'b0;
    bus.mem_rvalid  = 1'b0;
    if (cached.exists(a) != 0) begin
      bus.mem_rvalid = stray;
      bus.mem_rdata  = $urandom;
      #1;
      chk("hit_stall", bus.stall, 0);
      chk("hit_memreq", bus.mem_req, 0);
      chk("hit_wen", bus.cache_wen, 0);
      chk("hit_ren", bus.cache_ren, 1);
      tick();
      bus.mem_rvalid = 1'b0;
      #1;
      chk("hit_wdata_hold", bus.cache_wdata, last_block);
      return;
    end

    #1;
    chk("miss_stall", bus.stall, 1);
    chk("miss_ren", bus.cache_ren, 1);
    tick();
    bus.cache_hit = 1'b0;

    for (int i = 0; i <= gnt_dly; i++) begin
      bus.mem_gnt = (i == gnt_dly);
      #1;
      chk("req_memreq", bus.mem_req, 1);
      chk("req_addr", bus.mem_addr, {a, 4'h0});
      chk("req_baddr", bus.cache_baddr, a);
      check_busy("req");
      tick();
    end
    bus.mem_gnt = 1'b0;

    for (int b = 0; b < BEATS; b++) begin
      ng = (b == 0) ? 0 : ((gap < 0) ? int'($urandom_range(2, 0)) : gap);
      for (int g = 0; g < ng; g++) begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
        if (chg_addr) bus.fetch_baddr = 28'hABCDEF0;
        #1;
        chk("gap_memreq", bus.mem_req, 0);
        check_busy("gap");
        tick();
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = beats[b];
      if (chg_addr) bus.fetch_baddr = 28'hABCDEF0;
      #1;
      chk("fill_memreq", bus.mem_req, 0);
      check_busy("fill");
      tick();
    end

    bus.mem_rvalid = stray;
    bus.mem_rdata  = $urandom;
    #1;
    chk("wr_wen", bus.cache_wen, 1);
    chk("wr_ren", bus.cache_ren, 0);
    chk("wr_baddr", bus.cache_baddr, a);
    chk("wr_wdata", bus.cache_wdata, blk);
    chk("wr_stall", bus.stall, 1);
    chk("wr_memreq", bus.mem_req, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    cached[a] = 1'b1;
    if (exp_miss_cnt != 32'hFFFF_FFFF) exp_miss_cnt++;
    last_block = blk;
    exp_pulses++;

    bus.fetch_baddr = a;
    bus.cache_hit   = 1'b1;
    #1;
    chk("post_stall", bus.stall, 0);
    chk("post_ren", bus.cache_ren, 1);
    chk("post_wen", bus.cache_wen, 0);
    chk("post_miss_cnt", bus.miss_cnt, exp_miss_cnt);
    chk("post_wen_pulses", wen_pulses, exp_pulses);
    chk("post_wdata_hold", bus.cache_wdata, last_block);
    tick();
  endtask

  initial begin
    bus.fetch_ren = 0; bus.fetch_baddr = '0; bus.cache_hit = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    #12;
    chk("rst_ren", bus.cache_ren, 0);
    chk("rst_wen", bus.cache_wen, 0);
    chk("rst_memreq", bus.mem_req, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_miss_cnt", bus.miss_cnt, 0);
    chk("rst_memaddr", bus.mem_addr, 0);
    chk("rst_wdata", bus.cache_wdata, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset in the middle of a refill, after two of four beats.
    bus.fetch_ren = 1; bus.fetch_baddr = 28'h0000777; bus.cache_hit = 0;
    tick();
    bus.mem_gnt = 1;
    tick();
    bus.mem_gnt = 0;
    for (int b = 0; b < 2; b++) begin
      bus.mem_rvalid = 1; bus.mem_rdata = $urandom;
      tick();
    end
    bus.mem_rvalid = 0; bus.fetch_ren = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_memreq", bus.mem_req, 0);
    chk("arst_stall", bus.stall, 0);
    chk("arst_wen", bus.cache_wen, 0);
    chk("arst_miss_cnt", bus.miss_cnt, 0);
    chk("arst_wdata", bus.cache_wdata, 0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    bus.fetch_ren = 1; bus.cache_hit = 1;
    tick();
    chk("arst_idle_ren", bus.cache_ren, 1);
    chk("arst_idle_stall", bus.stall, 0);
    chk("arst_no_pulse", wen_pulses, 0);
    chk("arst_idle_memreq", bus.mem_req, 0);

    // Ten consecutive hits.
    for (int i = 0; i < 10; i++) begin
      bus.fetch_ren = 1; bus.cache_hit = 1; bus.fetch_baddr = BAB'($urandom);
      #1;
      chk("hit10_stall", bus.stall, 0);
      chk("hit10_memreq", bus.mem_req, 0);
      chk("hit10_wen", bus.cache_wen, 0);
      tick();
    end

    use_fixed = 1;
    fixed_beats[0] = 32'h11111111; fixed_beats[1] = 32'h22222222;
    fixed_beats[2] = 32'h33333333; fixed_beats[3] = 32'h44444444;
    do_access(28'h0000123, 0, 0, 0, 0);
    chk("t3_block", last_block, 128'h44444444_33333333_22222222_11111111);
    chk("t3_miss_cnt", bus.miss_cnt, 1);
    use_fixed = 0;

    do_access(28'h0000456, 3, 2, 0, 0);
    do_access(28'h0000789, 1, 1, 1, 0);
    do_access(28'h0000123, 0, 0, 0, 1);
    do_access(28'h0000AAA, 0, 0, 0, 1);
    do_access(28'h0000BBB, 2, -1, 0, 0);

    for (int i = 0; i < 16; i++) pool[i] = BAB'($urandom);
    for (int i = 0; i < 40; i++)
      do_access(pool[$urandom_range(15, 0)], int'($urandom_range(3, 0)), -1,
                $urandom_range(1, 0) != 0, $urandom_range(1, 0) != 0);

    chk("final_pulses", wen_pulses, exp_pulses);
    chk("final_miss_cnt", bus.miss_cnt, exp_miss_cnt);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
